// File: rtl/tile_load_sched.sv
// ---------------------------------------------------------------------------
// tile_load_sched
//
// Tile-level load sequencer for the load side of the conv datapath. One
// conv_start launches a layer of TILE_NUM tiles. For each tile a single
// load_start pulse is fanned out to DONE_NUM read masters. Their done pulses
// may arrive in any order, possibly in the same cycle, and possibly repeated.
// Once every master has reported, one conv_load_done pulse is emitted. The
// sequencer then waits for conv_store_done before starting the next tile.
// After the last tile is stored, conv_done pulses and the block returns to
// idle.
//
// Handshake protocol: every control input and output is a one-cycle pulse
// with no back-pressure. An input pulse is acted on only in the state that
// expects it and is otherwise dropped. Each output pulse is registered and
// is high for exactly one cycle.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-high reset
//   conv_start      pulse, start a layer (accepted only in IDLE)
//   rmst_load_done  per-master done pulses (accepted only in WAIT_LOAD)
//   conv_store_done pulse, current tile stored (accepted only in WAIT_STORE)
//   load_start      pulse to all read masters, once per tile
//   conv_load_done  pulse, all masters done for the current tile
//   conv_done       pulse, last tile of the layer stored
//   tile_idx        index of the current tile, 0..TILE_NUM-1
//   busy            high from tile 0 load_start until conv_done
//   load_cycles     cycle count of the most recent WAIT_LOAD period
// ---------------------------------------------------------------------------
module tile_load_sched #(
  parameter int TILE_NUM = 4,
  parameter int TILE_W   = 8,
  parameter int DONE_NUM = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conv_start,
  input  logic [DONE_NUM-1:0] rmst_load_done,
  input  logic                conv_store_done,
  output logic                load_start,
  output logic                conv_load_done,
  output logic                conv_done,
  output logic [TILE_W-1:0]   tile_idx,
  output logic                busy,
  output logic [CNT_W-1:0]    load_cycles
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_LOAD  = 2'd1,
    WAIT_STORE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(TILE_NUM - 1);

  state_t              state;
  logic [DONE_NUM-1:0] done_keep;
  logic [CNT_W-1:0]    cnt;

  // Done set including this cycle's pulses, so a master finishing on the
  // same edge as the others still completes the tile on that edge.
  logic [DONE_NUM-1:0] done_merged;
  logic                all_done;
  logic [CNT_W-1:0]    cnt_inc;

  always_comb begin
    done_merged = done_keep | rmst_load_done;
    all_done    = &done_merged;
    // Saturating increment: the latency counter never wraps.
    cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      done_keep      <= '0;
      cnt            <= '0;
      load_start     <= 1'b0;
      conv_load_done <= 1'b0;
      conv_done      <= 1'b0;
      tile_idx       <= '0;
      busy           <= 1'b0;
      load_cycles    <= '0;
    end else begin
      // Pulse outputs default low; each branch raises them for one cycle.
      load_start     <= 1'b0;
      conv_load_done <= 1'b0;
      conv_done      <= 1'b0;

      case (state)
        IDLE: begin
          if (conv_start) begin
            tile_idx   <= '0;
            load_start <= 1'b1;
            busy       <= 1'b1;
            done_keep  <= '0;
            cnt        <= '0;
            state      <= WAIT_LOAD;
          end
        end

        WAIT_LOAD: begin
          if (all_done) begin
            conv_load_done <= 1'b1;
            done_keep      <= '0;
            load_cycles    <= cnt_inc;
            cnt            <= '0;
            state          <= WAIT_STORE;
          end else begin
            done_keep <= done_merged;
            cnt       <= cnt_inc;
          end
        end

        WAIT_STORE: begin
          if (conv_store_done) begin
            if (tile_idx < LAST_TILE) begin
              tile_idx   <= tile_idx + 1'b1;
              load_start <= 1'b1;
              state      <= WAIT_LOAD;
            end else begin
              conv_done <= 1'b1;
              busy      <= 1'b0;
              tile_idx  <= '0;
              state     <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_load_sched.sv
// ---------------------------------------------------------------------------
// tb_tile_load_sched
//
// Directed bench for tile_load_sched. Three instances:
//   u_main : default parameters (TILE_NUM=4, DONE_NUM=3, CNT_W=16)
//   u_sat  : CNT_W=4, for latency counter saturation
//   u_one  : TILE_NUM=1, for single-tile and back-to-back layers
// Inputs are driven 1 ns after the rising edge; outputs are sampled there
// too, so each tick() observes the registers updated by that edge.
// A WAIT_LOAD cycle numbered k (1-based) is the k-th cycle in WAIT_LOAD,
// cycle 1 being the one in which load_start is high.
// ---------------------------------------------------------------------------
module tb_tile_load_sched;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_main signals
  logic        conv_start, conv_store_done;
  logic [2:0]  rmst;
  logic        load_start, conv_load_done, conv_done, busy;
  logic [7:0]  tile_idx;
  logic [15:0] load_cycles;

  // u_sat signals
  logic        s_start, s_store;
  logic [2:0]  s_rmst;
  logic        s_ls, s_cld, s_cd, s_busy;
  logic [7:0]  s_tile;
  logic [3:0]  s_cyc;

  // u_one signals
  logic        o_start, o_store;
  logic [2:0]  o_rmst;
  logic        o_ls, o_cld, o_cd, o_busy;
  logic [7:0]  o_tile;
  logic [15:0] o_cyc;

  tile_load_sched u_main (
    .clk(clk), .rst(rst), .conv_start(conv_start), .rmst_load_done(rmst),
    .conv_store_done(conv_store_done), .load_start(load_start),
    .conv_load_done(conv_load_done), .conv_done(conv_done),
    .tile_idx(tile_idx), .busy(busy), .load_cycles(load_cycles)
  );

  tile_load_sched #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .conv_start(s_start), .rmst_load_done(s_rmst),
    .conv_store_done(s_store), .load_start(s_ls),
    .conv_load_done(s_cld), .conv_done(s_cd),
    .tile_idx(s_tile), .busy(s_busy), .load_cycles(s_cyc)
  );

  tile_load_sched #(.TILE_NUM(1)) u_one (
    .clk(clk), .rst(rst), .conv_start(o_start), .rmst_load_done(o_rmst),
    .conv_store_done(o_store), .load_start(o_ls),
    .conv_load_done(o_cld), .conv_done(o_cd),
    .tile_idx(o_tile), .busy(o_busy), .load_cycles(o_cyc)
  );

  // pulse counters for u_main, sampled mid-cycle
  int n_ls, n_cld, n_cd;
  always @(negedge clk) begin
    if (!rst) begin
      if (load_start)     n_ls++;
      if (conv_load_done) n_cld++;
      if (conv_done)      n_cd++;
    end
  end

  // scoreboard
  int total, bad;
  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Run the WAIT_LOAD phase of u_main, entered in cycle 1 (load_start high).
  // t0/t0b/t1/t2: cycle of each done pulse (0 = none); n: cycles to run;
  // sp: cycle for a spurious conv_store_done (0 = none).
  task automatic wait_load(input string tag, input int t0, input int t0b,
                           input int t1, input int t2, input int n,
                           input int sp, input logic [15:0] exp_cyc);
    logic early;
    early = 1'b0;
    exp_q.push_back(exp_cyc);
    for (int k = 1; k <= n; k++) begin
      rmst[0]         = (k == t0) || (k == t0b);
      rmst[1]         = (k == t1);
      rmst[2]         = (k == t2);
      conv_store_done = (k == sp);
      tick();
      rmst            = '0;
      conv_store_done = 1'b0;
      if (k == 1 && n > 1) chk({tag, "_ls_clear"}, 32'(load_start), 32'd0);
      if (k < n && conv_load_done) early = 1'b1;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_cld"}, 32'(conv_load_done), 32'd1);
    chk({tag, "_cyc"}, 32'(load_cycles), 32'(exp_q.pop_front()));
  endtask

  // Run the WAIT_STORE phase of u_main: gap idle cycles, then store done.
  // spur injects conv_start and all done bits during the gap.
  task automatic store_phase(input string tag, input int gap, input logic last,
                             input int next_t, input logic spur);
    int ls_snap;
    ls_snap = n_ls;
    for (int i = 1; i <= gap; i++) begin
      if (spur && i == 2) begin
        conv_start = 1'b1;
        rmst       = 3'b111;
      end
      tick();
      conv_start = 1'b0;
      rmst       = '0;
      if (i == 1) chk({tag, "_cld_clear"}, 32'(conv_load_done), 32'd0);
    end
    chk({tag, "_no_ls"}, 32'(n_ls), 32'(ls_snap));
    conv_store_done = 1'b1;
    tick();
    conv_store_done = 1'b0;
    if (last) begin
      chk({tag, "_cd"}, 32'(conv_done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_tile"}, 32'(tile_idx), 32'd0);
    end else begin
      chk({tag, "_ls"}, 32'(load_start), 32'd1);
      chk({tag, "_tile"}, 32'(tile_idx), 32'(next_t));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    logic early;
    total = 0; bad = 0;
    rst = 1'b1;
    conv_start = 0; conv_store_done = 0; rmst = '0;
    s_start = 0; s_store = 0; s_rmst = '0;
    o_start = 0; o_store = 0; o_rmst = '0;

    // reset state
    repeat (2) tick();
    chk("rst_ls",   32'(load_start),     32'd0);
    chk("rst_cld",  32'(conv_load_done), 32'd0);
    chk("rst_cd",   32'(conv_done),      32'd0);
    chk("rst_tile", 32'(tile_idx),       32'd0);
    chk("rst_busy", 32'(busy),           32'd0);
    chk("rst_cyc",  32'(load_cycles),    32'd0);
    chk("rst_s_busy", 32'(s_busy), 32'd0);
    chk("rst_o_cyc",  32'(o_cyc),  32'd0);
    rst = 1'b0;
    tick();

    // spurious inputs in IDLE
    rmst = 3'b111; conv_store_done = 1'b1;
    tick();
    rmst = '0; conv_store_done = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ls_cnt", 32'(n_ls), 32'd0);
    chk("idle_cld_cnt", 32'(n_cld), 32'd0);

    // layer 1: nominal, dones at cycles 5, 9, 12
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    chk("l1_ls", 32'(load_start), 32'd1);
    chk("l1_busy", 32'(busy), 32'd1);
    chk("l1_tile", 32'(tile_idx), 32'd0);
    for (int t = 0; t < 4; t++) begin
      wait_load($sformatf("l1_t%0d", t), 5, 0, 9, 12, 12, (t == 1) ? 3 : 0, 16'd12);
      store_phase($sformatf("l1_s%0d", t), 20, (t == 3), t + 1, (t == 0));
    end
    tick();
    chk("l1_cd_clear", 32'(conv_done), 32'd0);
    chk("l1_n_ls", 32'(n_ls), 32'd4);
    chk("l1_n_cld", 32'(n_cld), 32'd4);
    chk("l1_n_cd", 32'(n_cd), 32'd1);

    // layer 2: simultaneous and duplicate dones
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    chk("l2_tile", 32'(tile_idx), 32'd0);
    wait_load("l2_t0", 3, 0, 3, 3, 3, 0, 16'd3);
    store_phase("l2_s0", 2, 1'b0, 1, 1'b0);
    wait_load("l2_t1", 2, 4, 6, 7, 7, 0, 16'd7);
    store_phase("l2_s1", 2, 1'b0, 2, 1'b0);
    wait_load("l2_t2", 1, 0, 1, 1, 1, 0, 16'd1);
    store_phase("l2_s2", 2, 1'b0, 3, 1'b0);
    wait_load("l2_t3", 3, 0, 3, 3, 3, 0, 16'd3);
    store_phase("l2_s3", 2, 1'b1, 0, 1'b0);
    tick();
    chk("l2_n_ls", 32'(n_ls), 32'd8);
    chk("l2_n_cld", 32'(n_cld), 32'd8);
    chk("l2_n_cd", 32'(n_cd), 32'd2);

    // layer 3: reset in WAIT_LOAD of tile 2 with 2 of 3 dones latched
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    wait_load("l3_t0", 1, 0, 1, 1, 1, 0, 16'd1);
    store_phase("l3_s0", 2, 1'b0, 1, 1'b0);
    wait_load("l3_t1", 1, 0, 1, 1, 1, 0, 16'd1);
    store_phase("l3_s1", 2, 1'b0, 2, 1'b0);
    rmst = 3'b001;
    tick();
    rmst = 3'b010;
    tick();
    rmst = '0;
    chk("l3_partial_cld", 32'(conv_load_done), 32'd0);
    rst = 1'b1;
    #1;
    chk("l3_rst_ls",   32'(load_start),     32'd0);
    chk("l3_rst_cld",  32'(conv_load_done), 32'd0);
    chk("l3_rst_cd",   32'(conv_done),      32'd0);
    chk("l3_rst_tile", 32'(tile_idx),       32'd0);
    chk("l3_rst_busy", 32'(busy),           32'd0);
    chk("l3_rst_cyc",  32'(load_cycles),    32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("l3_idle_busy", 32'(busy), 32'd0);
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    chk("l3_restart_ls", 32'(load_start), 32'd1);
    chk("l3_restart_tile", 32'(tile_idx), 32'd0);
    wait_load("l3_fresh", 5, 0, 5, 1, 5, 0, 16'd5);

    // saturation, CNT_W=4: last done withheld until WAIT_LOAD cycle 30
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("sat_ls", 32'(s_ls), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      s_rmst = (k == 1) ? 3'b011 : ((k == 30) ? 3'b100 : 3'b000);
      tick();
      s_rmst = '0;
      if (k < 30 && s_cld) early = 1'b1;
    end
    chk("sat_early", 32'(early), 32'd0);
    chk("sat_cld", 32'(s_cld), 32'd1);
    chk("sat_cyc", 32'(s_cyc), 32'd15);

    // TILE_NUM=1, back-to-back layers
    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    chk("one_ls", 32'(o_ls), 32'd1);
    chk("one_busy", 32'(o_busy), 32'd1);
    o_rmst = 3'b111;
    tick();
    o_rmst = '0;
    chk("one_cld", 32'(o_cld), 32'd1);
    chk("one_cyc", 32'(o_cyc), 32'd1);
    tick();
    chk("one_cld_clear", 32'(o_cld), 32'd0);
    o_store = 1'b1;
    tick();
    o_store = 1'b0;
    chk("one_cd", 32'(o_cd), 32'd1);
    chk("one_cd_busy", 32'(o_busy), 32'd0);
    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    chk("b2b_ls", 32'(o_ls), 32'd1);
    chk("b2b_busy", 32'(o_busy), 32'd1);
    chk("b2b_cd_clear", 32'(o_cd), 32'd0);
    // store done coincident with the final rmst done must be ignored
    o_rmst = 3'b111; o_store = 1'b1;
    tick();
    o_rmst = '0; o_store = 1'b0;
    chk("b2b_cld", 32'(o_cld), 32'd1);
    tick();
    tick();
    chk("b2b_store_ignored", 32'(o_cd), 32'd0);
    chk("b2b_still_busy", 32'(o_busy), 32'd1);
    o_store = 1'b1;
    tick();
    o_store = 1'b0;
    chk("b2b_cd", 32'(o_cd), 32'd1);
    chk("b2b_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
